// File: rtl/pic_rw_ctrl.sv
// Bus interface and command-register block for an 8259A-compatible PIC.
// Synchronises CPU strobes, sequences ICW1..ICW4, decodes OCWs and muxes read-back data.
module pic_rw_ctrl #(
  parameter int DW = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DW-1:0] RESET_IMR = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CS,
  input  logic          Read,
  input  logic          write,
  input  logic          A0,
  input  logic [DW-1:0] dataBuffer,
  input  logic [DW-1:0] irr_in,
  input  logic [DW-1:0] isr_in,
  input  logic          write_flag_ACK,
  output logic          write_flag,
  output logic [2:0]    write_sel,
  output logic [DW-1:0] ICW1,
  output logic [DW-1:0] ICW2,
  output logic [DW-1:0] ICW3,
  output logic [DW-1:0] ICW4,
  output logic [DW-1:0] OCW1,
  output logic [DW-1:0] OCW2,
  output logic [DW-1:0] OCW3,
  output logic          init_done,
  output logic          cmd_error,
  output logic          read_cmd_to_ctrl_logic,
  output logic [DW-1:0] dataOut,
  output logic          dataOut_en,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
  logic cs_s, rd_s, wr_s, wr_prev;
  logic wr_fall, wr_rise;
  logic cap_valid, cap_a0, cap_rd, commit;
  logic [DW-1:0] cap_data;
  logic read_isr;
  logic acc;
  logic [2:0] code;
  logic rd_active;

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign wr_fall = wr_prev & ~wr_s;
  assign wr_rise = ~wr_prev & wr_s;

  // A write during which Read was also seen low is still accepted, but flagged.
  assign rd_active = ~rd_s & ~cs_s & wr_s;
  assign read_cmd_to_ctrl_logic = rd_active;
  assign dbg_state = state;

  always_comb begin
    acc       = 1'b0;
    code      = 3'd0;
    state_nxt = state;
    if (!cap_a0 && cap_data[4]) begin
      acc = 1'b1;
      code = 3'd0;
    end else if (!cap_a0) begin
      acc  = (state == READY);
      code = cap_data[3] ? 3'd6 : 3'd5;
    end else begin
      case (state)
        WAIT_ICW2: begin acc = 1'b1; code = 3'd1; end
        WAIT_ICW3: begin acc = 1'b1; code = 3'd2; end
        WAIT_ICW4: begin acc = 1'b1; code = 3'd3; end
        READY:     begin acc = 1'b1; code = 3'd4; end
        default:   begin acc = 1'b0; code = 3'd0; end
      endcase
    end
    if (commit && acc) begin
      case (code)
        3'd0: state_nxt = WAIT_ICW2;
        3'd1: state_nxt = !ICW1[1] ? WAIT_ICW3 : (ICW1[0] ? WAIT_ICW4 : READY);
        3'd2: state_nxt = ICW1[0] ? WAIT_ICW4 : READY;
        3'd3: state_nxt = READY;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync    <= '1;
      rd_sync    <= '1;
      wr_sync    <= '1;
      wr_prev    <= 1'b1;
      cap_valid  <= 1'b0;
      cap_a0     <= 1'b0;
      cap_rd     <= 1'b0;
      cap_data   <= '0;
      commit     <= 1'b0;
      state      <= IDLE;
      init_done  <= 1'b0;
      read_isr   <= 1'b0;
      ICW1       <= '0;
      ICW2       <= '0;
      ICW3       <= '0;
      ICW4       <= '0;
      OCW1       <= RESET_IMR;
      OCW2       <= '0;
      OCW3       <= '0;
      write_flag <= 1'b0;
      write_sel  <= 3'd0;
      cmd_error  <= 1'b0;
      dataOut    <= '0;
      dataOut_en <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], Read};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], write};
      wr_prev <= wr_s;

      if (wr_fall && !cs_s) begin
        cap_valid <= 1'b1;
        cap_a0    <= A0;
        cap_data  <= dataBuffer;
        cap_rd    <= ~rd_s;
      end else if (cap_valid && !rd_s) begin
        cap_rd <= 1'b1;
      end

      commit <= 1'b0;
      if (wr_rise && cap_valid) begin
        cap_valid <= 1'b0;
        commit    <= 1'b1;
      end

      state     <= state_nxt;
      init_done <= (state_nxt == READY);
      cmd_error <= commit && (!acc || cap_rd);

      if (commit && acc) begin
        case (code)
          3'd0: begin
            ICW1     <= cap_data;
            ICW2     <= '0;
            ICW3     <= '0;
            ICW4     <= '0;
            OCW2     <= '0;
            OCW1     <= RESET_IMR;
            read_isr <= 1'b0;
          end
          3'd1: ICW2 <= cap_data;
          3'd2: ICW3 <= cap_data;
          3'd3: ICW4 <= cap_data;
          3'd4: OCW1 <= cap_data;
          3'd5: OCW2 <= cap_data;
          default: begin
            OCW3 <= cap_data;
            if (cap_data[1]) read_isr <= cap_data[0];
          end
        endcase
      end

      if (commit && acc) begin
        write_flag <= 1'b1;
        write_sel  <= code;
      end else if (write_flag_ACK) begin
        write_flag <= 1'b0;
      end

      dataOut_en <= rd_active;
      if (rd_active)
        dataOut <= A0 ? OCW1 : (read_isr ? isr_in : irr_in);
      else
        dataOut <= '0;
    end
  end

endmodule

// File: tb/tb_pic_rw_ctrl.sv
// Directed bench for pic_rw_ctrl with a register-level model of the command interface.
module tb_pic_rw_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       CS = 1'b1, Read = 1'b1, write = 1'b1, A0 = 1'b0;
  logic [7:0] dataBuffer = '0, irr_in = '0, isr_in = '0;
  logic       write_flag_ACK = 1'b0;
  logic       write_flag, init_done, cmd_error, read_cmd_to_ctrl_logic, dataOut_en;
  logic [2:0] write_sel, dbg_state;
  logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, dataOut;

  pic_rw_ctrl #(.DW(8), .SYNC_STAGES(2), .RESET_IMR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .Read(Read), .write(write), .A0(A0),
    .dataBuffer(dataBuffer), .irr_in(irr_in), .isr_in(isr_in),
    .write_flag_ACK(write_flag_ACK), .write_flag(write_flag), .write_sel(write_sel),
    .ICW1(ICW1), .ICW2(ICW2), .ICW3(ICW3), .ICW4(ICW4),
    .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3), .init_done(init_done),
    .cmd_error(cmd_error), .read_cmd_to_ctrl_logic(read_cmd_to_ctrl_logic),
    .dataOut(dataOut), .dataOut_en(dataOut_en), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  // Model: stage 0 = not initialised, 1..3 = awaiting ICW2..ICW4, 4 = ready.
  int         m_stage;
  logic [7:0] m_icw[1:4];
  logic [7:0] m_ocw[1:3];
  bit         m_isr, m_flag;
  int         m_sel;
  int         m_err;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stage = 0; m_isr = 0; m_flag = 0; m_sel = 0;
    for (int i = 1; i <= 4; i++) m_icw[i] = 8'h00;
    for (int i = 1; i <= 3; i++) m_ocw[i] = 8'h00;
  endtask

  task automatic model_accept(input int sel);
    m_flag = 1; m_sel = sel;
  endtask

  task automatic model_write(input bit a0, input logic [7:0] d);
    if (!a0 && d[4]) begin
      m_icw[1] = d; m_icw[2] = 0; m_icw[3] = 0; m_icw[4] = 0;
      m_ocw[1] = 8'h00; m_ocw[2] = 0; m_isr = 0; m_stage = 1;
      model_accept(0);
    end else if (!a0) begin
      if (m_stage != 4) m_err++;
      else if (!d[3]) begin m_ocw[2] = d; model_accept(5); end
      else begin
        m_ocw[3] = d;
        if (d[1]) m_isr = d[0];
        model_accept(6);
      end
    end else begin
      case (m_stage)
        1: begin
          m_icw[2] = d; model_accept(1);
          if (!m_icw[1][1]) m_stage = 2; else if (m_icw[1][0]) m_stage = 3; else m_stage = 4;
        end
        2: begin m_icw[3] = d; model_accept(2); m_stage = m_icw[1][0] ? 3 : 4; end
        3: begin m_icw[4] = d; model_accept(3); m_stage = 4; end
        4: begin m_ocw[1] = d; model_accept(4); end
        default: m_err++;
      endcase
    end
  endtask

  always @(negedge clk) if (cmd_error) err_cnt++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ICW1", ICW1, m_icw[1]);
      chk("ICW2", ICW2, m_icw[2]);
      chk("ICW3", ICW3, m_icw[3]);
      chk("ICW4", ICW4, m_icw[4]);
      chk("OCW1", OCW1, m_ocw[1]);
      chk("OCW2", OCW2, m_ocw[2]);
      chk("OCW3", OCW3, m_ocw[3]);
      chk("init_done", init_done, (m_stage == 4));
      chk("write_flag", write_flag, m_flag);
      if (m_flag) chk("write_sel", write_sel, m_sel);
    end
  end

  task automatic cpu_write(input bit cs_n, input bit a0, input logic [7:0] d);
    chk_en = 0;
    @(negedge clk);
    CS = cs_n; A0 = a0; dataBuffer = d;
    repeat (2) @(negedge clk);
    write = 0;
    repeat (6) @(negedge clk);
    write = 1;
    repeat (6) @(negedge clk);
    CS = 1;
    repeat (2) @(negedge clk);
    if (!cs_n) model_write(a0, d);
    chk("cmd_error_count", err_cnt, m_err);
    chk_en = 1;
  endtask

  task automatic cpu_read(input bit a0, input logic [7:0] lit);
    logic [7:0] mexp;
    mexp = a0 ? m_ocw[1] : (m_isr ? isr_in : irr_in);
    exp_q.push_back(lit);
    @(negedge clk);
    CS = 0; A0 = a0; Read = 0;
    repeat (5) @(negedge clk);
    chk("read_cmd", read_cmd_to_ctrl_logic, 1'b1);
    chk("dataOut_en", dataOut_en, 1'b1);
    chk("dataOut_model", dataOut, mexp);
    chk("dataOut_lit", dataOut, exp_q.pop_front());
    Read = 1; CS = 1;
    repeat (5) @(negedge clk);
    chk("dataOut_en_off", dataOut_en, 1'b0);
  endtask

  task automatic ack_pulse();
    chk_en = 0;
    @(negedge clk);
    write_flag_ACK = 1;
    @(posedge clk);
    #1 write_flag_ACK = 0;
    m_flag = 0;
    @(negedge clk);
    chk("flag_after_ack", write_flag, 1'b0);
    chk_en = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_icw"}, {ICW1, ICW2, ICW3, ICW4}, 32'h0);
    chk({tag, "_ocw"}, {OCW1, OCW2, OCW3}, 24'h0);
    chk({tag, "_ctl"}, {write_flag, write_sel, init_done, cmd_error,
                        read_cmd_to_ctrl_logic, dataOut_en}, 8'h0);
    chk({tag, "_dout"}, dataOut, 8'h00);
  endtask

  initial begin
    model_reset();
    m_err = 0;
    #23;
    check_reset_outputs("reset");
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;

    // Rejected and ignored writes before initialisation.
    cpu_write(0, 0, 8'h20);
    chk("ocw2_pre_init", OCW2, 8'h00);
    cpu_write(1, 1, 8'hA5);
    chk("cs_high_err", err_cnt, 1);

    // Single mode with ICW4.
    cpu_write(0, 0, 8'h13);
    chk("sel_icw1", write_sel, 3'd0);
    cpu_write(0, 1, 8'h20);
    chk("sel_icw2", write_sel, 3'd1);
    chk("not_ready_yet", init_done, 1'b0);
    cpu_write(0, 1, 8'h01);
    chk("sel_icw4", write_sel, 3'd3);
    chk("init_done_single", init_done, 1'b1);
    chk("icw3_zero", ICW3, 8'h00);

    // Cascade mode with ICW4.
    cpu_write(0, 0, 8'h11);
    cpu_write(0, 1, 8'h08);
    cpu_write(0, 1, 8'h04);
    chk("icw3_cascade", ICW3, 8'h04);
    chk("not_ready_cascade", init_done, 1'b0);
    cpu_write(0, 1, 8'h1D);
    chk("icw4_cascade", ICW4, 8'h1D);
    chk("init_done_cascade", init_done, 1'b1);

    // OCW1 and handshake.
    cpu_write(0, 1, 8'h55);
    chk("ocw1_val", OCW1, 8'h55);
    chk("sel_ocw1", write_sel, 3'd4);
    repeat (10) @(negedge clk);
    chk("flag_held", write_flag, 1'b1);
    ack_pulse();

    // Read-back selection.
    isr_in = 8'h80; irr_in = 8'h01;
    cpu_write(0, 0, 8'h0B);
    chk("sel_ocw3", write_sel, 3'd6);
    cpu_read(0, 8'h80);
    cpu_write(0, 0, 8'h08);
    cpu_read(0, 8'h80);
    cpu_write(0, 0, 8'h0A);
    cpu_read(0, 8'h01);
    cpu_read(1, 8'h55);

    // OCW2 accepted once ready.
    cpu_write(0, 0, 8'h20);
    chk("ocw2_ready", OCW2, 8'h20);
    chk("sel_ocw2", write_sel, 3'd5);

    // Reset while waiting for ICW3.
    cpu_write(0, 0, 8'h11);
    cpu_write(0, 1, 8'h08);
    chk("in_wait_icw3", dbg_state, 3'd2);
    chk_en = 0;
    #3 rst_n = 0;
    #1;
    check_reset_outputs("midinit");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    cpu_write(0, 1, 8'h08);
    chk("icw2_after_reset", ICW2, 8'h00);
    chk("flag_after_reset", write_flag, 1'b0);

    chk_en = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_rw_ctrl.md
Name: pic_rw_ctrl

Overview:
Clocked, parametrised bus-interface and command-register block for the 8259A-compatible PIC. It synchronises the asynchronous CPU strobes and sequences ICW1..ICW4 with an initialisation FSM. It decodes OCW1..OCW3 once initialisation completes, hands each accepted write to control logic via a flag/ACK handshake, and drives the read-back mux (IRR/ISR/IMR).

Parameters:
DW, 8, data bus and register width (ICW/OCW bit fields use bits [4:0], so DW >= 8)
SYNC_STAGES, 2, synchroniser depth for CS, Read, write (>= 2)
RESET_IMR, 8'h00, OCW1 (mask) value after reset and after ICW1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
CS  in  1  chip select, active low, asynchronous
Read  in  1  read strobe, active low, asynchronous
write  in  1  write strobe, active low, asynchronous
A0  in  1  register address bit
dataBuffer  in  DW  CPU write data
irr_in  in  DW  interrupt request register from priority logic
isr_in  in  DW  in-service register from priority logic
write_flag_ACK  in  1  control logic consumed the last write
write_flag  out  1  an accepted write is pending
write_sel  out  3  register written: 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1 5=OCW2 6=OCW3
ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3  out  DW each  command registers
init_done  out  1  FSM in READY
cmd_error  out  1  one-cycle pulse, rejected write
read_cmd_to_ctrl_logic  out  1  valid read cycle in progress
dataOut  out  DW  read-back data
dataOut_en  out  1  drive enable for the bus buffer

Behaviour:
- Clock and reset: one clock; rst_n is asynchronous and active-low.
- Reset: all ICW/OCW2/OCW3 = 0, OCW1 = RESET_IMR, FSM = IDLE, read_sel = IRR, write_flag = 0, write_sel = 0, cmd_error = 0, init_done = 0, dataOut = 0, dataOut_en = 0, read_cmd_to_ctrl_logic = 0, synchronisers cleared to 1 (inactive). Reset mid-cycle aborts any pending write.
- CS, Read and write pass through SYNC_STAGES flops. wr_fall and wr_rise are detected on the synchronised write.
- Write capture: on wr_fall with synchronised CS = 0, latch A0 and dataBuffer and set cap_valid. On wr_rise with cap_valid set, commit and clear cap_valid. If CS is high at wr_fall, nothing is captured and nothing commits.
- Commit latency: registers and write_flag update on the cycle after the wr_rise detection.
- Decode at commit:
  - A0=0, D4=1: ICW1. Load ICW1, clear ICW2..ICW4 and OCW2, OCW1 = RESET_IMR, read_sel = IRR, FSM -> WAIT_ICW2. Legal in any state.
  - A0=0, D4=0, D3=0: OCW2. Accepted only in READY.
  - A0=0, D4=0, D3=1: OCW3. Accepted only in READY. If bit1 (RR) = 1, read_sel = bit0 ? ISR : IRR; if RR = 0, read_sel is unchanged.
  - A0=1 in WAIT_ICW2: load ICW2. Next state is WAIT_ICW3 if ICW1[1] = 0 (cascade), else WAIT_ICW4 if ICW1[0] = 1, else READY.
  - A0=1 in WAIT_ICW3: load ICW3. Next state is WAIT_ICW4 if ICW1[0] = 1, else READY.
  - A0=1 in WAIT_ICW4: load ICW4, go to READY.
  - A0=1 in READY: load OCW1.
  - Any other write (OCW while IDLE/WAIT_*, A0=1 in IDLE): no register change, no write_flag, cmd_error pulses 1 cycle.
- Handshake: write_flag sets on an accepted commit and write_sel holds the code. The flag clears on the cycle after write_flag_ACK = 1. If a new commit coincides with ACK, write_flag stays 1 and write_sel takes the new code. write_sel is held while the flag is 1.
- Read: read_cmd_to_ctrl_logic = synchronised Read = 0 and CS = 0 and write = 1. dataOut_en equals it, registered.
- Read data: dataOut is registered each cycle while reading. A0 = 1 gives OCW1; A0 = 0 gives irr_in or isr_in per read_sel.
- Read and write simultaneous: write wins, read outputs stay 0, cmd_error pulses once on the commit.
- Back-to-back writes need no ACK between them; the later commit overwrites write_sel.

Test Plan:
- Reset, then ICW1=8'h13 (single, IC4), ICW2=8'h20, ICW4=8'h01 -> FSM IDLE->W2->W4->READY; ICW3 stays 0; init_done=1 after the third commit; write_sel 0,1,3.
- ICW1=8'h11 (cascade, IC4), ICW2=8'h08, ICW3=8'h04, ICW4=8'h1D -> all four loaded, init_done after the fourth commit.
- After init, A0=1 data 8'h55 -> OCW1=8'h55, write_flag=1, write_sel=4. Hold ACK low: flag stays 1. Pulse ACK: flag clears the next cycle.
- OCW3=8'h0B then read A0=0 with isr_in=8'h80, irr_in=8'h01 -> dataOut=8'h80. OCW3=8'h08 then read -> still 8'h80. OCW3=8'h0A -> 8'h01. Read A0=1 -> 8'h55.
- Before init: A0=0 data 8'h20 (OCW2) -> cmd_error pulse, OCW2 stays 0, write_flag stays 0. Write with CS high -> no change at all.
- Mid-init (WAIT_ICW3), assert rst_n=0 -> all outputs return to reset values immediately. A later ICW2-style write (A0=1) -> cmd_error.
